// File: rtl/btn_pkg.sv
// Shared types and constants for the push-button input conditioning stage.
package btn_pkg;

  localparam int unsigned SYNC_STAGES = 2;

  typedef logic [1:0] btn_t;

  localparam btn_t BTN_NONE = 2'b00;
  localparam btn_t BTN_0    = 2'b01;
  localparam btn_t BTN_1    = 2'b10;
  localparam btn_t BTN_BOTH = 2'b11;

endpackage : btn_pkg

// File: rtl/debounce.sv
// One button bit: two-flop synchronizer, stability counter and press (0->1) detect.
module debounce
  import btn_pkg::*;
#(
  parameter int unsigned DB_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic lvl,
  output logic rise
);

  localparam int unsigned CW = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   lvl_q, lvl_d;
  logic                   s;
  logic                   done;

  assign s    = sync_q[SYNC_STAGES-1];
  assign done = (cnt_q == CW'(DB_CYC - 1));

  // Rise is asserted on the very edge that flips the accepted level to 1,
  // so downstream logic captures it together with the level change.
  assign rise = s & ~lvl_q & done;
  assign lvl  = lvl_q;

  // Next accepted level and stability count; any bounce back restarts the count.
  always_comb begin
    cnt_d = '0;
    lvl_d = lvl_q;
    if (s != lvl_q) begin
      if (done) begin
        lvl_d = s;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchronizer chain plus debounce state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      lvl_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      cnt_q  <= cnt_d;
      lvl_q  <= lvl_d;
    end
  end

endmodule : debounce

// File: rtl/btn_window.sv
// Conditions two raw buttons and reports presses seen in each fixed window,
// with a one-cycle window pulse that qualifies the captured presses.
module btn_window
  import btn_pkg::*;
#(
  parameter int unsigned PERIOD_CYC = 200_000_000,
  parameter int unsigned DB_CYC     = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] btn,
  output logic [1:0] in,
  output logic       enb2s
);

  localparam int unsigned CW = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;

  btn_t          rise;
  btn_t          lvl_unused;
  logic [CW-1:0] cnt_q, cnt_d;
  btn_t          sticky_q, sticky_d;
  btn_t          in_q, in_d;
  logic          enb_q, enb_d;
  logic          wend;

  debounce #(.DB_CYC(DB_CYC)) u_db0 (
    .clk  (clk),
    .rst  (rst),
    .raw  (btn[0]),
    .lvl  (lvl_unused[0]),
    .rise (rise[0])
  );

  debounce #(.DB_CYC(DB_CYC)) u_db1 (
    .clk  (clk),
    .rst  (rst),
    .raw  (btn[1]),
    .lvl  (lvl_unused[1]),
    .rise (rise[1])
  );

  assign wend = (cnt_q == CW'(PERIOD_CYC - 1));

  // Window bookkeeping: a rise on the closing edge lands in the current report.
  always_comb begin
    cnt_d    = wend ? '0 : cnt_q + 1'b1;
    enb_d    = wend;
    in_d     = wend ? (sticky_q | rise) : in_q;
    sticky_d = wend ? BTN_NONE : (sticky_q | rise);
  end

  // Free-running window counter, sticky press accumulator and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      sticky_q <= BTN_NONE;
      in_q     <= BTN_NONE;
      enb_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      in_q     <= in_d;
      enb_q    <= enb_d;
    end
  end

  assign in    = in_q;
  assign enb2s = enb_q;

endmodule : btn_window

// File: tb/tb_btn_window.sv
// Directed bench for btn_window with PERIOD_CYC=20, DB_CYC=4.
// Cycle k = the k-th rising edge after reset release; btn for cycle k is
// driven just after edge k and first sampled at edge k+1.
module tb_btn_window;
  import btn_pkg::*;

  localparam int unsigned PER = 20;

  logic clk = 1'b0;
  logic rst = 1'b0;
  btn_t btn = BTN_NONE;
  btn_t in_w;
  logic enb2s;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  btn_t pat    [0:79];
  btn_t exp_in [0:3];

  btn_window #(.PERIOD_CYC(PER), .DB_CYC(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn),
    .in    (in_w),
    .enb2s (enb2s)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clr();
    for (int i = 0; i < 80; i++) pat[i] = BTN_NONE;
    for (int i = 0; i < 4; i++) exp_in[i] = BTN_NONE;
  endtask

  // Hold reset for ncyc edges, optionally checking the outputs stay cleared.
  task automatic do_reset(input int ncyc, input bit check);
    btn = BTN_NONE;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk);
      #1;
      if (check) begin
        chk("rst_enb", {31'd0, enb2s}, 32'd0);
        chk("rst_in", {30'd0, in_w}, 32'd0);
      end
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Run ncyc cycles from release, applying pat[] and checking every cycle.
  task automatic run(input string name, input int ncyc);
    btn_t held;
    bit   pulse;
    held = BTN_NONE;
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clk);
      #1;
      pulse = ((k % PER) == PER - 1);
      if (pulse) held = exp_in[k / PER];
      chk({name, "_enb"}, {31'd0, enb2s}, {31'd0, pulse});
      chk({name, "_in"}, {30'd0, in_w}, {30'd0, held});
      btn = pat[k];
    end
    btn = BTN_NONE;
  endtask

  initial begin
    // Reset and free-running period
    clr();
    do_reset(5, 1'b1);
    run("period", 60);

    // Clean press of button 0: level rises at cycle 9, reported at 19 only
    clr();
    for (int i = 3; i <= 12; i++) pat[i] = BTN_0;
    exp_in[0] = BTN_0;
    do_reset(2, 1'b0);
    run("clean", 40);

    // Button 1 held forever: reported only in the window of its rise
    clr();
    for (int i = 3; i < 80; i++) pat[i] = BTN_1;
    exp_in[0] = BTN_1;
    do_reset(2, 1'b0);
    run("held", 60);

    // 3-high / 2-low / 3-high glitch never reaches DB_CYC stable cycles
    clr();
    for (int i = 3; i <= 5; i++) pat[i] = BTN_1;
    for (int i = 8; i <= 10; i++) pat[i] = BTN_1;
    do_reset(2, 1'b0);
    run("glitch", 40);

    // Rise lands exactly on the window-end edge (cycle 19)
    clr();
    for (int i = 13; i <= 30; i++) pat[i] = BTN_0;
    exp_in[0] = BTN_0;
    do_reset(2, 1'b0);
    run("coinc", 40);

    // Two presses of button 0 plus one of button 1 in the same window
    clr();
    for (int i = 0; i <= 5; i++) pat[i][0] = 1'b1;
    for (int i = 12; i <= 25; i++) pat[i][0] = 1'b1;
    for (int i = 4; i <= 10; i++) pat[i][1] = 1'b1;
    exp_in[0] = BTN_BOTH;
    do_reset(2, 1'b0);
    run("multi", 40);

    // Reset mid-window after both buttons were captured
    clr();
    for (int i = 2; i <= 14; i++) pat[i] = BTN_BOTH;
    do_reset(2, 1'b0);
    run("mid", 16);
    rst = 1'b0;
    #1;
    chk("mid_rst_enb", {31'd0, enb2s}, 32'd0);
    chk("mid_rst_in", {30'd0, in_w}, 32'd0);
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("mid_hold_enb", {31'd0, enb2s}, 32'd0);
      chk("mid_hold_in", {30'd0, in_w}, 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    clr();
    run("mid_post", 40);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_btn_window
